// File: rtl/secuenciador_filtro.sv
// secuenciador_filtro: sample sequencer on the producer side of a filter.
// An upstream sample is held in a one-entry register and issued to the
// filter as a one-clock `rx` strobe at the start of a fixed-length slot.
// The sequencer then waits for `rx_2`, captures `y`, and offers the result
// on a valid/ready output port.
//
// Handshakes (both ports): a transfer happens on a rising clock edge where
// valid && ready are both high. A producer holds valid and data stable
// until that edge. `in_ready` is a register: it is high while the holding
// register is empty. `out_valid` is held until the result is taken. A new
// capture still overwrites an unread result, and that sets `overrun`.
//
// Optional feature: define SEQ_TIMEOUT_EN to bound the wait for `rx_2` to
// TIMEOUT clocks. When a wait times out, sticky `timeout_err` is set.
// Without the macro there is no timeout counter, `timeout_err` is tied low,
// and the wait for `rx_2` never ends on its own.
module secuenciador_filtro #(
    parameter int PERIODO = 16,
    parameter int TIMEOUT = 64,
    parameter int W       = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         rx,
    output logic [W-1:0] u,
    input  logic         rx_2,
    input  logic [W-1:0] y,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [7:0]   slot_miss,
    output logic         overrun,
    output logic         timeout_err,
    output logic [1:0]   fsm_state
);

    localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(PERIODO - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STROBE    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] slot_cnt;
    logic          tick;
    logic          hold_full;
    logic [W-1:0]  hold_data;
    logic          miss_evt;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wait_cnt;
`else
    // No timeout hardware in this build; the comparison is constant false.
    assign timeout_err = (TIMEOUT < 0);
`endif

    assign tick      = (slot_cnt == SLOT_LAST);
    assign in_ready  = ~hold_full;
    assign fsm_state = state;
    // A slot is lost when its tick finds the sequencer busy or nothing held.
    assign miss_evt  = tick && ((state != IDLE) || !hold_full);

    // Free-running slot counter, 0..PERIODO-1.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Sequencer FSM together with the holding register, the strobe outputs,
    // result capture and the status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_full   <= 1'b0;
            hold_data   <= '0;
            rx          <= 1'b0;
            u           <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            slot_miss   <= 8'd0;
            overrun     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            rx <= 1'b0;

            if (in_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= in_data;
            end

            // A capture later in this block overrides this clear.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (miss_evt && (slot_miss != 8'hFF)) begin
                slot_miss <= slot_miss + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (tick && hold_full) begin
                        state <= STROBE;
                        rx    <= 1'b1;
                        u     <= hold_data;
                    end
                end
                STROBE: begin
                    // The register frees only now, so `in_ready` stays low
                    // through the strobe cycle.
                    hold_full <= 1'b0;
                    state     <= WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                WAIT_DONE: begin
                    if (rx_2) begin
                        out_data  <= y;
                        out_valid <= 1'b1;
                        if (out_valid && !out_ready) begin
                            overrun <= 1'b1;
                        end
                        state <= IDLE;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Self-checking bench for secuenciador_filtro. A small filter model answers
// each strobe with y = u + 1 after a chosen latency. A slot-level reference
// model predicts every output on every clock.
module tb_secuenciador_filtro;

    localparam int P  = 16;
    localparam int TO = 64;
    localparam int W  = 25;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         rx;
    logic [W-1:0] u;
    logic         rx_2;
    logic [W-1:0] y;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [7:0]   slot_miss;
    logic         overrun;
    logic         timeout_err;
    logic [1:0]   fsm_state;

    secuenciador_filtro #(.PERIODO(P), .TIMEOUT(TO), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rx(rx), .u(u), .rx_2(rx_2), .y(y),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .slot_miss(slot_miss), .overrun(overrun), .timeout_err(timeout_err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: slot phase, held sample, wait window, results.
    int           cyc, ph, strobe_at, m_wlen, m_miss;
    bit           m_pend, m_wait, m_ov, m_overrun, m_tout;
    logic [W-1:0] m_data, m_u, m_od;
    // Filter model and bench bookkeeping.
    int           f_done, lat_lo, lat_hi;
    logic [W-1:0] f_y;
    bit           rx2_force, acc_last, spacing_on;
    int           n_rx, n_res, last_rx, n_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            if (n_errors <= 30)
                $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        ph = 0; strobe_at = -1; m_wlen = 0; m_miss = 0;
        m_pend = 0; m_wait = 0; m_ov = 0; m_overrun = 0; m_tout = 0;
        m_data = '0; m_u = '0; m_od = '0;
        last_rx = -1;
    endfunction

    // Apply the rules of one slot-clock to the model using the current inputs.
    task automatic model_update();
        bit old_pend, old_wait, old_ov, is_tick, is_strobe;
        int lat;
        if (rst) begin
            model_reset();
            return;
        end
        old_pend  = m_pend;
        old_wait  = m_wait;
        old_ov    = m_ov;
        is_tick   = (ph == P - 1);
        is_strobe = (cyc == strobe_at);
        if (in_valid && !old_pend) begin
            m_pend = 1; m_data = in_data;
        end
        if (old_ov && out_ready) m_ov = 0;
        if (old_wait) begin
            if (rx_2) begin
                if (old_ov && !out_ready) m_overrun = 1;
                m_ov = 1; m_od = y; m_wait = 0;
            end else if (TOUT_EN && m_wlen == TO - 1) begin
                m_tout = 1; m_wait = 0;
            end else begin
                m_wlen++;
            end
        end
        if (is_strobe) begin
            m_pend = 0; m_wait = 1; m_wlen = 0;
        end
        if (is_tick) begin
            if (!old_wait && !is_strobe && old_pend) begin
                strobe_at = cyc + 1;
                m_u = m_data;
                if (lat_lo > 0) begin
                    lat = $urandom_range(lat_hi, lat_lo);
                    f_done = strobe_at + lat;
                    f_y = m_data + 1;
                end else begin
                    f_done = -1;
                end
            end else if (m_miss < 255) begin
                m_miss++;
            end
        end
        ph = (ph + 1) % P;
    endtask

    // One clock: drive the filter, advance the model, then check all outputs.
    task automatic step();
        rx_2 = (cyc == f_done) || rx2_force;
        y = f_y;
        if (out_valid === 1'b1 && out_ready && !rst) n_res++;
        acc_last = in_valid && !m_pend && !rst;
        model_update();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("in_ready", in_ready, !m_pend);
        chk("rx", rx, cyc == strobe_at);
        chk("u", u, m_u);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("slot_miss", slot_miss, m_miss);
        chk("overrun", overrun, m_overrun);
        chk("timeout_err", timeout_err, m_tout);
        if (rx === 1'b1) begin
            n_rx++;
            if (spacing_on && last_rx >= 0) chk("strobe_spacing", cyc - last_rx, P);
            last_rx = cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 200; i++) begin
            step();
            if (acc_last) break;
        end
        chk("push_accepted", acc_last, 1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rx2_force = 1'b0; f_done = -1;
        step();
        step();
        rst = 1'b0;
        n_rx = 0; n_res = 0; last_rx = -1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rx_2 = 1'b0; y = '0;
        cyc = 0; f_done = -1; f_y = '0; lat_lo = 1; lat_hi = 1;
        rx2_force = 0; spacing_on = 0; n_rx = 0; n_res = 0; n_acc = 0; acc_last = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values, then a single sample through a 15-clock filter.
        do_reset();
        lat_lo = 15; lat_hi = 15;
        run(2);
        push(25'h0000ABC);
        run(40);
        chk("single_strobes", n_rx, 1);
        chk("single_out_data", out_data, 25'h0000ABD);
        chk("single_out_valid", out_valid, 1);

        // Continuous stream: strobes every P clocks, no misses, all results.
        do_reset();
        lat_lo = 2; lat_hi = 12;
        out_ready = 1'b1;
        spacing_on = 1;
        n_acc = 0;
        in_valid = 1'b1;
        in_data = W'($urandom);
        for (int i = 0; i < 20000 && n_acc < 1000; i++) begin
            step();
            if (acc_last) begin
                n_acc++;
                in_data = W'($urandom);
            end
        end
        chk("stream_accepts", n_acc, 1000);
        chk("stream_slot_miss", slot_miss, 0);
        in_valid = 1'b0;
        run(40);
        spacing_on = 0;
        chk("stream_strobes", n_rx, 1000);
        chk("stream_results", n_res, 1000);
        chk("stream_overrun", overrun, 0);

        // No input at all: misses saturate and nothing is strobed.
        do_reset();
        run(300 * P);
        chk("idle_slot_miss", slot_miss, 255);
        chk("idle_strobes", n_rx, 0);

        // Two results left unread: the second overwrites and flags overrun.
        do_reset();
        lat_lo = 5; lat_hi = 5;
        push(25'd4);
        run(20);
        push(25'd8);
        run(25);
        chk("ovr_out_data", out_data, 9);
        chk("ovr_out_valid", out_valid, 1);
        chk("ovr_flag", overrun, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("ovr_drained", out_valid, 0);

`ifdef SEQ_TIMEOUT_EN
        // Filter never answers: the wait times out and the next sample goes out.
        do_reset();
        lat_lo = 0;
        push(25'h55);
        run(19);
        push(25'h66);
        run(110);
        chk("tout_flag", timeout_err, 1);
        chk("tout_strobes", n_rx, 2);
        chk("tout_out_valid", out_valid, 0);
`endif

        // Reset in the middle of a wait; the late rx_2 must not be captured.
        do_reset();
        lat_lo = 30; lat_hi = 30;
        push(25'h123);
        run(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        run(40);
        chk("rst_late_out_valid", out_valid, 0);
        chk("rst_late_out_data", out_data, 0);

        // Random traffic: gaps, back-pressure, long latencies, stray rx_2.
        do_reset();
        lat_lo = 1; lat_hi = 30;
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                in_data = W'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            rx2_force = ($urandom_range(0, 19) == 0);
            step();
            if (acc_last) in_valid = 1'b0;
        end
        rx2_force = 1'b0;
        in_valid = 1'b0;
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
